// File: rtl/xor_tree_arb.sv
// Two-requester round-robin front end for a shared combinational XOR tree.
// One request is in flight at a time: IDLE accepts, EVAL samples the tree, RESP holds the result.
module xor_tree_arb #(
  parameter int N_VEC = 5,
  parameter int WIDTH = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [N_VEC*WIDTH-1:0]   req_vec0,
  input  logic [N_VEC*WIDTH-1:0]   req_vec1,
  output logic [N_VEC*WIDTH-1:0]   tree_in,
  input  logic [WIDTH-1:0]         tree_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [N_VEC*WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]         res_data_q, res_data_d;
  logic                     res_id_q, res_id_d;
  logic                     id_q, id_d;
  logic                     last_q, last_d;
  logic                     grant;
  logic                     accept;

  // With both requesters active, the one not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant = ~last_q;
    end
  end

  assign accept    = (state_q == IDLE) && (|req_valid) && rst_n;
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    id_d       = id_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          operand_d = grant ? req_vec1 : req_vec0;
          id_d      = grant;
          last_d    = grant;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        res_data_d = tree_out;
        res_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      operand_q  <= '0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      id_q       <= id_d;
      last_q     <= last_d;
    end
  end

  assign tree_in   = operand_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xor_tree_arb.sv
// Bench for xor_tree_arb: a behavioural XOR tree on tree_in/tree_out and a
// result scoreboard filled when requests are driven and drained on handshakes.
module tb_xor_tree_arb;

  localparam int N_VEC = 5;
  localparam int WIDTH = 31;
  localparam int VW    = N_VEC * WIDTH;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [VW-1:0]    req_vec0;
  logic [VW-1:0]    req_vec1;
  logic [VW-1:0]    tree_in;
  logic [WIDTH-1:0] tree_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic lastGrant;

  xor_tree_arb #(.N_VEC(N_VEC), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vec0  (req_vec0),
    .req_vec1  (req_vec1),
    .tree_in   (tree_in),
    .tree_out  (tree_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] xorWords(input logic [VW-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N_VEC; k++) r = r ^ v[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // The shared 5x31 XOR tree that the arbiter fronts.
  always_comb begin
    tree_out = xorWords(tree_in);
  end

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int k = 0; k < N_VEC; k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom());
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Every handshake on the result side pops the oldest expected result;
  // also watches that no cycle grants both requesters.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("ready_onehot", {159'd0, ($countones(req_ready) <= 1)}, 160'd1);
    if (rst_n && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_empty", 160'd1, 160'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("res_data", {129'd0, res_data}, {129'd0, e.data});
        checkOutput("res_id", {159'd0, res_id}, {159'd0, e.id});
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
  task automatic applyStimulus(input logic [1:0] valid, input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                               input int holdCycles, input bit keepValid);
    logic             g;
    logic [VW-1:0]    chosen;
    logic [WIDTH-1:0] expData;
    req_vec0  = v0;
    req_vec1  = v1;
    req_valid = valid;
    res_ready = (holdCycles == 0);
    if (valid == 2'b10)      g = 1'b1;
    else if (valid == 2'b11) g = ~lastGrant;
    else                     g = 1'b0;
    chosen  = g ? v1 : v0;
    expData = xorWords(chosen);

    @(negedge clk);
    checkOutput("req_ready_grant", {158'd0, req_ready}, {158'd0, (g ? 2'b10 : 2'b01)});
    checkOutput("busy_idle", {159'd0, busy}, 160'd0);
    expQ.push_back('{id: g, data: expData});
    lastGrant = g;

    @(posedge clk); #1;
    if (!keepValid) req_valid = 2'b00;
    @(negedge clk);
    checkOutput("eval_ready", {158'd0, req_ready}, 160'd0);
    checkOutput("eval_busy", {159'd0, busy}, 160'd1);
    checkOutput("eval_valid", {159'd0, res_valid}, 160'd0);
    checkOutput("tree_in", {5'd0, tree_in}, {5'd0, chosen});

    @(posedge clk); #1;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {159'd0, res_valid}, 160'd1);
      checkOutput("hold_data", {129'd0, res_data}, {129'd0, expData});
      checkOutput("hold_id", {159'd0, res_id}, {159'd0, g});
      checkOutput("hold_ready", {158'd0, req_ready}, 160'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("resp_valid", {159'd0, res_valid}, 160'd1);
    checkOutput("resp_busy", {159'd0, busy}, 160'd1);
    @(posedge clk); #1;
    checkOutput("back_idle", {159'd0, busy}, 160'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, {158'd0, req_ready}, 160'd0);
    checkOutput({tag, "_res_valid"}, {159'd0, res_valid}, 160'd0);
    checkOutput({tag, "_busy"}, {159'd0, busy}, 160'd0);
    checkOutput({tag, "_res_data"}, {129'd0, res_data}, 160'd0);
    checkOutput({tag, "_res_id"}, {159'd0, res_id}, 160'd0);
    checkOutput({tag, "_tree_in"}, {5'd0, tree_in}, 160'd0);
  endtask

  initial begin
    logic [VW-1:0] vecA;
    logic [VW-1:0] r0;
    vecA = {31'd478163327, 31'd107420369, 31'd1181241943, 31'd1051802512, 31'd958682846};

    rst_n     = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    req_vec0  = randVec();
    req_vec1  = randVec();
    lastGrant = 1'b1;
    #1 rst_n = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters held active from release: 0,1,0,1.
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, randVec(), randVec(), 0, 1'b1);

    applyStimulus(2'b01, vecA, randVec(), 0, 1'b0);
    applyStimulus(2'b10, randVec(), '0, 0, 1'b0);
    applyStimulus(2'b11, randVec(), randVec(), 5, 1'b0);
    applyStimulus(2'b01, randVec(), randVec(), 0, 1'b0);

    // Reset while a request sits in EVAL: result must vanish.
    r0        = randVec();
    req_vec0  = r0;
    req_valid = 2'b01;
    @(negedge clk);
    checkOutput("pre_reset_grant", {158'd0, req_ready}, 160'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    checkOutput("pre_reset_busy", {159'd0, busy}, 160'd1);
    rst_n = 1'b0;
    #1 checkAllZero("mid_reset");
    lastGrant = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_valid", {159'd0, res_valid}, 160'd0);
    end
    @(posedge clk); #1;
    applyStimulus(2'b11, randVec(), randVec(), 0, 1'b0);

    checkOutput("sb_drained", 160'(expQ.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
